rvb_shifter_pipe: RTL and testbench
===================================

Name: rvb_shifter_pipe

Overview:
- Parametrised successor to the single-stage bitmanip shifter unit: XLEN-wide shift/rotate/shift-ones engine with a configurable pipeline depth.
- Full-throughput valid/ready handshake with bubble collapsing and a sideband tag that travels alongside each operation.
- Sits in the execute stage beside the ALU.
- Optional funnel-shift mode reads a third operand.

Parameters:
XLEN, 32, datapath width; 32 or 64 only.
STAGES, 2, pipeline depth and latency in cycles; 1..3.
TAGW, 4, width of the sideband tag carried with each operation.

Ports:
clock  in  1  clock.
reset  in  1  synchronous, active-low reset.
din_valid  in  1  input operation valid.
din_ready  out  1  unit accepts the operation this cycle.
din_op  in  4  0 SLL, 1 SRL, 2 SRA, 3 SLO, 4 SRO, 5 ROL, 6 ROR, 7 FSL, 8 FSR, 9-15 reserved.
din_w  in  1  word (32-bit) variant; ignored when XLEN=32.
din_rs1  in  XLEN  data operand.
din_rs2  in  XLEN  shift-amount operand.
din_rs3  in  XLEN  funnel second operand (FSL/FSR only).
din_tag  in  TAGW  sideband, returned unchanged.
dout_valid  out  1  result valid.
dout_ready  in  1  consumer accepts the result.
dout_rd  out  XLEN  result.
dout_tag  out  TAGW  tag of the operation in dout_rd.

Behaviour:
- Reset (reset==0 at a clock edge):
  - all stage valid bits cleared; dout_valid=0, dout_rd=0, dout_tag=0.
  - any in-flight operation is discarded.
  - din_ready=1 in the first cycle after release.
- Transfers:
  - An input transfer occurs on a clock edge with din_valid && din_ready.
  - An output transfer occurs on a clock edge with dout_valid && dout_ready.
- Pipeline:
  - Registers S1..S_STAGES, each with its own valid bit; S_STAGES drives dout_*.
  - Stage i advances when it is empty, or when S(i+1) is empty or advancing. S_STAGES advances when it is empty or dout_ready=1.
  - din_ready = S1 can advance. This is combinational from dout_ready only through the advance chain.
  - Bubbles collapse: an empty stage never blocks upstream.
- Latency and throughput:
  - Latency is exactly STAGES cycles with no backpressure.
  - Throughput is 1 operation/cycle when dout_ready is held high.
- Simultaneous input and output transfer on a full pipe is legal and loses nothing.
- Data stability:
  - While dout_valid=1 and dout_ready=0, dout_rd and dout_tag hold stable.
  - Internal stage contents never change while stalled.
- Work split:
  - STAGES=1: whole computation in S1.
  - STAGES>=2: S1 decodes the op, computes the shift amount and conditionally bit-reverses the operand for left shifts; the last stage does the final shift and merge. With STAGES=3, S2 is a plain register slice.
- Shift amount:
  - sh = rs2[log2(XLEN)-1:0].
  - With din_w=1 and XLEN=64: sh = rs2[4:0], operate on rs1[31:0], and sign-extend the 32-bit result from bit 31.
- Op semantics for shift amount sh:
  - SLL: rs1<<sh.
  - SRL: rs1>>sh (logical).
  - SRA: arithmetic right shift.
  - SLO: ~(~rs1<<sh).
  - SRO: ~(~rs1>>sh).
  - ROL, ROR: rotates.
- sh=0 returns rs1 unchanged for every non-funnel op.
- Ops 7/8 without the feature, and ops 9-15: rd=0. These are still accepted and complete with normal latency.

Optional Feature:
RVB_SHIFTER_FUNNEL_EN
- Defined: ops 7/8 implement funnel shifts.
  - Shift amount: m = rs2[log2(XLEN):0], i.e. modulo 2*XLEN.
  - Operand select: A=rs1, B=rs3. If m>=XLEN, then m-=XLEN and A and B are swapped.
  - FSL: rd = m ? (A<<m)|(B>>(XLEN-m)) : A.
  - FSR: rd = m ? (A>>m)|(B<<(XLEN-m)) : A.
  - With din_w=1 and XLEN=64: use 32-bit A/B, m=rs2[5:0], and sign-extend the result from bit 31.
- Undefined: no rs3 datapath is built; din_rs3 is unused; ops 7/8 return 0.

Test Plan:
- Latency, XLEN=32, STAGES=2, dout_ready=1: SLL rs1=0x00000001, rs2=31, tag=5 -> dout_rd=0x80000000, dout_tag=5 exactly 2 cycles after acceptance.
- Full op sweep, STAGES=1 and 3, XLEN=32:
  - SRA rs1=0x80000000, rs2=4 -> 0xF8000000.
  - SLO rs1=0, rs2=4 -> 0x0000000F.
  - ROR rs1=0x00000001, rs2=1 -> 0x80000000.
  - Op 12 -> 0.
- Backpressure:
  - Stream 8 ops back-to-back while holding dout_ready=0 for 5 cycles.
  - Required: din_ready=0 once all STAGES are full; no op lost or duplicated; tags emerge in order 0..7; dout_rd stable while stalled.
- Word variant, XLEN=64: SRLW with din_w=1, rs1=0xFFFFFFFF_80000000, rs2=0 -> 0xFFFFFFFF_80000000; SLLW with rs1=1, rs2=31 -> 0xFFFFFFFF_80000000.
- Funnel, with RVB_SHIFTER_FUNNEL_EN, XLEN=32:
  - FSL rs1=0x12345678, rs3=0x9ABCDEF0, rs2=8 -> 0x3456789A.
  - Same with rs2=40 -> 0xBCDEF012.
  - Without the macro, both -> 0.
- Reset mid-stream: drive reset=0 for one cycle with 2 ops in flight -> dout_valid=0 next cycle; dout_rd=0; no stale op emerges; din_ready=1 after release.

Source files
------------

// File: rtl/rvb_shifter_pipe.sv
// rvb_shifter_pipe: XLEN-wide shift / rotate / shift-ones engine for the
// execute stage, with a configurable pipeline depth and a sideband tag that
// travels with each operation.
//
// Every operation is rewritten into a single form: a right shift of the
// double-width value {hi, lo} by sh, keeping the low XLEN bits. Left-going
// ops bit-reverse their operands going in and bit-reverse the result coming
// out. Word ops (XLEN=64, din_w=1) pack {hi32, lo32} into lo so the same
// shifter yields the 32-bit answer in the low half, which is then
// sign-extended from bit 31.
//
// Optional feature: define RVB_SHIFTER_FUNNEL_EN to build the rs3 datapath
// and make ops 7/8 (FSL/FSR) funnel shifts. Without it ops 7/8 return 0.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. A stage may load when it is empty or when its contents
// leave on the same edge, so bubbles never block upstream and a full pipe
// sustains one op per cycle with dout_ready held high.
//
// Ports:
//   clock, reset            clock; synchronous active-low reset
//   din_valid / din_ready   operation handshake
//   din_op                  0 SLL 1 SRL 2 SRA 3 SLO 4 SRO 5 ROL 6 ROR 7 FSL 8 FSR
//   din_w                   32-bit word variant (XLEN=64 only)
//   din_rs1/rs2/rs3         data, shift amount, funnel second operand
//   din_tag                 sideband, returned unchanged with the result
//   dout_valid / dout_ready result handshake
//   dout_rd, dout_tag       result and its tag
module rvb_shifter_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAGW   = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            din_valid,
   output logic            din_ready,
   input  logic [3:0]      din_op,
   input  logic            din_w,
   input  logic [XLEN-1:0] din_rs1,
   input  logic [XLEN-1:0] din_rs2,
   input  logic [XLEN-1:0] din_rs3,
   input  logic [TAGW-1:0] din_tag,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic [XLEN-1:0] dout_rd,
   output logic [TAGW-1:0] dout_tag
);
   localparam int LG = $clog2(XLEN);
   localparam logic [XLEN-1:0] MASK32 = XLEN'(64'h0000_0000_FFFF_FFFF);

   localparam logic [3:0] OP_SLL = 4'd0, OP_SRL = 4'd1, OP_SRA = 4'd2,
                          OP_SLO = 4'd3, OP_SRO = 4'd4, OP_ROL = 4'd5,
                          OP_ROR = 4'd6, OP_FSL = 4'd7, OP_FSR = 4'd8;

   // Decoded operation, held between the front and back halves.
   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
      logic [LG-1:0]   sh;
      logic            rev;
      logic            word;
      logic [TAGW-1:0] tag;
   } mid_t;

   function automatic logic [31:0] rev32(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = x[31-i];
      return r;
   endfunction

   function automatic logic [XLEN-1:0] rev_x(input logic [XLEN-1:0] x);
      logic [XLEN-1:0] r;
      for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
      return r;
   endfunction

   // Reverse within the effective width (32 bits for word ops).
   function automatic logic [XLEN-1:0] rev_e(input logic [XLEN-1:0] x, input logic word);
      return word ? XLEN'(rev32(x[31:0])) : rev_x(x);
   endfunction

   // Final shift, un-reverse and word sign extension.
   function automatic logic [XLEN-1:0] back_end(input mid_t m);
      logic [2*XLEN-1:0] wide;
      logic [XLEN-1:0]   r;
      logic [31:0]       r32;
      wide = {m.hi, m.lo} >> m.sh;
      r    = wide[XLEN-1:0];
      r32  = m.rev ? rev32(r[31:0]) : r[31:0];
      if (m.word) return r32[31] ? (~MASK32 | XLEN'(r32)) : XLEN'(r32);
      return m.rev ? rev_x(r) : r;
   endfunction

   // ---------------- front half: decode, amount, operand select ----------
   logic            dw, sign_e, rev_f;
   logic [XLEN-1:0] a_e, ones_e, hi_e, lo_e;
   logic [LG-1:0]   sh_e, sh_f;
   mid_t            front;
   logic            unused_ok;

`ifdef RVB_SHIFTER_FUNNEL_EN
   logic [XLEN-1:0] b_e, fa, fb;
   logic [LG:0]     fun_m;
   logic            fun_wrap;
   logic [LG-1:0]   fun_sh;
   assign unused_ok = ^din_rs2;
`else
   assign unused_ok = ^{din_rs2, din_rs3};
`endif

   always_comb begin
      dw     = (XLEN == 64) && din_w;
      a_e    = dw ? (din_rs1 & MASK32) : din_rs1;
      ones_e = dw ? MASK32 : '1;
      sign_e = dw ? din_rs1[31] : din_rs1[XLEN-1];
      sh_e   = dw ? LG'(din_rs2[4:0]) : din_rs2[LG-1:0];
      hi_e   = '0;
      lo_e   = '0;
      sh_f   = sh_e;
      rev_f  = 1'b0;
`ifdef RVB_SHIFTER_FUNNEL_EN
      b_e      = dw ? (din_rs3 & MASK32) : din_rs3;
      fun_m    = dw ? (LG+1)'(din_rs2[5:0]) : din_rs2[LG:0];
      // m >= effective width: drop the top bit and swap the operands.
      fun_wrap = dw ? fun_m[5] : fun_m[LG];
      fun_sh   = dw ? LG'(fun_m[4:0]) : fun_m[LG-1:0];
      fa       = fun_wrap ? b_e : a_e;
      fb       = fun_wrap ? a_e : b_e;
`endif
      case (din_op)
         OP_SLL: begin lo_e = rev_e(a_e, dw); rev_f = 1'b1; end
         OP_SRL: lo_e = a_e;
         OP_SRA: begin hi_e = sign_e ? ones_e : '0; lo_e = a_e; end
         OP_SLO: begin hi_e = ones_e; lo_e = rev_e(a_e, dw); rev_f = 1'b1; end
         OP_SRO: begin hi_e = ones_e; lo_e = a_e; end
         OP_ROL: begin hi_e = rev_e(a_e, dw); lo_e = rev_e(a_e, dw); rev_f = 1'b1; end
         OP_ROR: begin hi_e = a_e; lo_e = a_e; end
`ifdef RVB_SHIFTER_FUNNEL_EN
         OP_FSL: begin
            hi_e = rev_e(fb, dw); lo_e = rev_e(fa, dw); sh_f = fun_sh; rev_f = 1'b1;
         end
         OP_FSR: begin hi_e = fb; lo_e = fa; sh_f = fun_sh; end
`endif
         default: rev_f = 1'b0;  // hi = lo = 0 gives rd = 0
      endcase
      front.hi   = dw ? '0 : hi_e;
      front.lo   = dw ? ((hi_e << 32) | lo_e) : lo_e;
      front.sh   = sh_f;
      front.rev  = rev_f;
      front.word = dw;
      front.tag  = din_tag;
   end

   // ---------------- pipeline registers and advance chain ----------------
   mid_t            m1_q, m1_d, m2_q, m2_d;
   logic            m1_v_q, m1_v_d, m2_v_q, m2_v_d, o_v_q, o_v_d;
   logic [XLEN-1:0] o_rd_q, o_rd_d;
   logic [TAGW-1:0] o_tag_q, o_tag_d;
   logic            adv_o, adv_1, adv_2;

   always_comb begin
      adv_o   = !o_v_q  || dout_ready;
      adv_2   = !m2_v_q || adv_o;
      adv_1   = !m1_v_q || ((STAGES == 3) ? adv_2 : adv_o);
      m1_d    = m1_q;   m1_v_d = m1_v_q;
      m2_d    = m2_q;   m2_v_d = m2_v_q;
      o_v_d   = o_v_q;  o_rd_d = o_rd_q;  o_tag_d = o_tag_q;
      if (STAGES == 1) begin
         din_ready = adv_o;
         if (adv_o) begin
            o_v_d = din_valid;
            if (din_valid) begin o_rd_d = back_end(front); o_tag_d = din_tag; end
         end
      end else begin
         din_ready = adv_1;
         if (adv_1) begin
            m1_v_d = din_valid;
            if (din_valid) m1_d = front;
         end
         if (STAGES == 3) begin
            // plain register slice between decode and final shift
            if (adv_2) begin
               m2_v_d = m1_v_q;
               if (m1_v_q) m2_d = m1_q;
            end
            if (adv_o) begin
               o_v_d = m2_v_q;
               if (m2_v_q) begin o_rd_d = back_end(m2_q); o_tag_d = m2_q.tag; end
            end
         end else if (adv_o) begin
            o_v_d = m1_v_q;
            if (m1_v_q) begin o_rd_d = back_end(m1_q); o_tag_d = m1_q.tag; end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         m1_v_q  <= 1'b0;  m1_q <= '0;
         m2_v_q  <= 1'b0;  m2_q <= '0;
         o_v_q   <= 1'b0;
         o_rd_q  <= '0;
         o_tag_q <= '0;
      end else begin
         m1_v_q  <= m1_v_d;  m1_q <= m1_d;
         m2_v_q  <= m2_v_d;  m2_q <= m2_d;
         o_v_q   <= o_v_d;
         o_rd_q  <= o_rd_d;
         o_tag_q <= o_tag_d;
      end
   end

   assign dout_valid = o_v_q;
   assign dout_rd    = o_rd_q;
   assign dout_tag   = o_tag_q;
endmodule

// File: tb/tb_rvb_shifter_pipe.sv
module tb_rvb_shifter_pipe;
  localparam logic [3:0] OP_SLL = 4'd0, OP_SRL = 4'd1, OP_SRA = 4'd2, OP_SLO = 4'd3,
                         OP_SRO = 4'd4, OP_ROL = 4'd5, OP_ROR = 4'd6, OP_FSL = 4'd7,
                         OP_FSR = 4'd8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Shared stimulus; din_valid is steered to one instance by sel.
  // sel 0: XLEN32/STAGES2, 1: XLEN32/STAGES1, 2: XLEN32/STAGES3, 3: XLEN64/STAGES2
  int          sel = 0;
  logic        din_valid = 1'b0, din_w = 1'b0, dout_ready = 1'b1;
  logic [3:0]  din_op = '0, din_tag = '0;
  logic [63:0] din_rs1 = '0, din_rs2 = '0, din_rs3 = '0;
  logic        dv [4];
  logic        rdy [4];
  logic        ov [4];
  logic [31:0] ord [3];
  logic [63:0] ord64;
  logic [3:0]  otag [4];
  logic        cur_ready, cur_valid;
  logic [63:0] cur_rd;
  logic [3:0]  cur_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always_comb begin
    for (int k = 0; k < 4; k++) dv[k] = din_valid && (sel == k);
  end

  always_comb begin
    cur_ready = rdy[0]; cur_valid = ov[0]; cur_rd = 64'(ord[0]); cur_tag = otag[0];
    case (sel)
      1: begin cur_ready = rdy[1]; cur_valid = ov[1]; cur_rd = 64'(ord[1]); cur_tag = otag[1]; end
      2: begin cur_ready = rdy[2]; cur_valid = ov[2]; cur_rd = 64'(ord[2]); cur_tag = otag[2]; end
      3: begin cur_ready = rdy[3]; cur_valid = ov[3]; cur_rd = ord64;        cur_tag = otag[3]; end
      default: ;
    endcase
  end

  rvb_shifter_pipe #(.XLEN(32), .STAGES(2), .TAGW(4)) u_s2 (
    .clock(clock), .reset(reset), .din_valid(dv[0]), .din_ready(rdy[0]), .din_op(din_op),
    .din_w(din_w), .din_rs1(din_rs1[31:0]), .din_rs2(din_rs2[31:0]), .din_rs3(din_rs3[31:0]),
    .din_tag(din_tag), .dout_valid(ov[0]), .dout_ready(dout_ready), .dout_rd(ord[0]),
    .dout_tag(otag[0]));
  rvb_shifter_pipe #(.XLEN(32), .STAGES(1), .TAGW(4)) u_s1 (
    .clock(clock), .reset(reset), .din_valid(dv[1]), .din_ready(rdy[1]), .din_op(din_op),
    .din_w(din_w), .din_rs1(din_rs1[31:0]), .din_rs2(din_rs2[31:0]), .din_rs3(din_rs3[31:0]),
    .din_tag(din_tag), .dout_valid(ov[1]), .dout_ready(dout_ready), .dout_rd(ord[1]),
    .dout_tag(otag[1]));
  rvb_shifter_pipe #(.XLEN(32), .STAGES(3), .TAGW(4)) u_s3 (
    .clock(clock), .reset(reset), .din_valid(dv[2]), .din_ready(rdy[2]), .din_op(din_op),
    .din_w(din_w), .din_rs1(din_rs1[31:0]), .din_rs2(din_rs2[31:0]), .din_rs3(din_rs3[31:0]),
    .din_tag(din_tag), .dout_valid(ov[2]), .dout_ready(dout_ready), .dout_rd(ord[2]),
    .dout_tag(otag[2]));
  rvb_shifter_pipe #(.XLEN(64), .STAGES(2), .TAGW(4)) u_x64 (
    .clock(clock), .reset(reset), .din_valid(dv[3]), .din_ready(rdy[3]), .din_op(din_op),
    .din_w(din_w), .din_rs1(din_rs1), .din_rs2(din_rs2), .din_rs3(din_rs3),
    .din_tag(din_tag), .dout_valid(ov[3]), .dout_ready(dout_ready), .dout_rd(ord64),
    .dout_tag(otag[3]));

  function automatic int stages_of(input int s);
    case (s)
      1: return 1;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Issues one op with dout_ready high, returns result, tag and latency
  // (cycles from the acceptance cycle to the cycle dout_valid is seen).
  task automatic do_op(input int s, input logic [3:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] tg, output logic [63:0] rd, output logic [3:0] rt,
                       output int lat);
    int n;
    @(negedge clock);
    sel = s; din_op = op; din_w = w; din_rs1 = a; din_rs2 = b; din_rs3 = c;
    din_tag = tg; din_valid = 1'b1; dout_ready = 1'b1;
    #1;
    n = 0;
    while (!cur_ready && n < 20) begin @(negedge clock); #1; n++; end
    @(posedge clock);
    @(negedge clock);
    din_valid = 1'b0;
    lat = 1;
    while (!cur_valid && lat < 20) begin @(negedge clock); lat++; end
    rd = cur_rd; rt = cur_tag;
    @(posedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      n_tests++;
      if (cur_ready !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready[%0d]: got %b expected 1", s, cur_ready); end
      n_tests++;
      if (cur_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid[%0d]: got %b expected 0", s, cur_valid); end
      n_tests++;
      if (cur_rd !== 64'h0 || cur_tag !== 4'h0) begin
        n_fail++; $display("FAIL reset_dout[%0d]: got rd=%h tag=%h expected 0/0", s, cur_rd, cur_tag);
      end
    end
  endtask

  task automatic test_latency();
    logic [63:0] rd; logic [3:0] rt; int lat;
    for (int s = 0; s < 3; s++) begin
      do_op(s, OP_SLL, 1'b0, 64'h1, 64'd31, 64'h0, 4'd5, rd, rt, lat);
      n_tests++;
      if (rd !== 64'h8000_0000 || rt !== 4'd5) begin
        n_fail++; $display("FAIL latency_data[%0d]: got rd=%h tag=%0d expected 80000000/5", s, rd, rt);
      end
      n_tests++;
      if (lat !== stages_of(s)) begin
        n_fail++; $display("FAIL latency_cycles[%0d]: got %0d expected %0d", s, lat, stages_of(s));
      end
    end
  endtask

  task automatic test_op_sweep();
    logic [3:0]  t_op [11];
    logic [31:0] t_a [11];
    logic [31:0] t_b [11];
    logic [31:0] t_e [11];
    logic [63:0] rd; logic [3:0] rt; int lat;
    t_op = '{OP_SRA, OP_SLO, OP_ROR, 4'd12, OP_SRL, OP_SRO, OP_ROL, OP_SLL, OP_ROR, OP_SRA, OP_SLL};
    t_a  = '{32'h8000_0000, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h8000_0001,
             32'h1234_5678, 32'h1234_5678, 32'h7FFF_FFFF, 32'h1234_5678};
    t_b  = '{32'd4, 32'd4, 32'd1, 32'd3, 32'd4, 32'd4, 32'd4, 32'd0, 32'd32, 32'd31, 32'd36};
    t_e  = '{32'hF800_0000, 32'h0000_000F, 32'h8000_0000, 32'h0, 32'h0800_0000, 32'hF000_0000,
             32'h0000_0018, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h2345_6780};
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 11; i++) begin
        do_op(s, t_op[i], 1'b0, 64'(t_a[i]), 64'(t_b[i]), 64'h9ABC_DEF0, 4'(i), rd, rt, lat);
        n_tests++;
        if (rd !== 64'(t_e[i]) || rt !== 4'(i) || lat !== stages_of(s)) begin
          n_fail++;
          $display("FAIL sweep[%0d.%0d] op%0d: got rd=%h tag=%0d lat=%0d expected %h/%0d/%0d",
                   s, i, t_op[i], rd, rt, lat, t_e[i], i, stages_of(s));
        end
      end
    end
  endtask

  task automatic test_word();
    logic [3:0]  t_op [7];
    logic        t_w [7];
    logic [63:0] t_a [7];
    logic [63:0] t_b [7];
    logic [63:0] t_e [7];
    logic [63:0] rd; logic [3:0] rt; int lat;
    t_op = '{OP_SRL, OP_SLL, OP_SRA, OP_SLL, OP_SLL, OP_ROR, OP_ROR};
    t_w  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    t_a  = '{64'hFFFF_FFFF_8000_0000, 64'h1, 64'h0000_0000_8000_0000, 64'hDEAD_BEEF_0000_0001,
             64'h1, 64'h1, 64'h1};
    t_b  = '{64'd0, 64'd31, 64'd4, 64'd36, 64'd63, 64'd1, 64'd1};
    t_e  = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_F800_0000,
             64'h10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000_0000_0000};
    for (int i = 0; i < 7; i++) begin
      do_op(3, t_op[i], t_w[i], t_a[i], t_b[i], 64'h0, 4'(i + 3), rd, rt, lat);
      n_tests++;
      if (rd !== t_e[i] || rt !== 4'(i + 3)) begin
        n_fail++; $display("FAIL word[%0d]: got rd=%h tag=%0d expected %h/%0d", i, rd, rt, t_e[i], i + 3);
      end
    end
  endtask

  task automatic test_funnel();
    logic [3:0]  t_op [5];
    int          t_s [5];
    logic        t_w [5];
    logic [63:0] t_a [5];
    logic [63:0] t_b [5];
    logic [63:0] t_e [5];
    logic [63:0] rd; logic [3:0] rt; int lat;
    t_op = '{OP_FSL, OP_FSL, OP_FSR, OP_FSL, OP_FSL};
    t_s  = '{0, 0, 0, 3, 3};
    t_w  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t_a  = '{64'h1234_5678, 64'h1234_5678, 64'h1234_5678, 64'hFFFF_FFFF_1234_5678,
             64'hFFFF_FFFF_1234_5678};
    t_b  = '{64'd8, 64'd40, 64'd8, 64'd8, 64'd40};
`ifdef RVB_SHIFTER_FUNNEL_EN
    t_e  = '{64'h3456_789A, 64'hBCDE_F012, 64'hF012_3456, 64'h0000_0000_3456_789A,
             64'hFFFF_FFFF_BCDE_F012};
`else
    t_e  = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
`endif
    for (int i = 0; i < 5; i++) begin
      do_op(t_s[i], t_op[i], t_w[i], t_a[i], t_b[i], 64'h9ABC_DEF0, 4'(i + 9), rd, rt, lat);
      n_tests++;
      if (rd !== t_e[i] || rt !== 4'(i + 9)) begin
        n_fail++; $display("FAIL funnel[%0d]: got rd=%h tag=%0d expected %h/%0d", i, rd, rt, t_e[i], i + 9);
      end
    end
  endtask

  // 8 SRL ops back-to-back, dout_ready low for the first 5 cycles.
  task automatic test_back_to_back(input int s);
    logic [35:0] exp_q[$];
    logic [35:0] e;
    logic [63:0] prev_rd;
    logic [3:0]  prev_tag;
    logic        stall_prev;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; prev_rd = '0; prev_tag = '0;
    sel = s;
    while (got < 8 && cyc < 60) begin
      @(negedge clock);
      dout_ready = (cyc >= 5);
      if (sent < 8) begin
        din_op = OP_SRL; din_w = 1'b0; din_rs1 = 64'h8000_0000; din_rs2 = 64'(sent);
        din_tag = sent[3:0]; din_valid = 1'b1;
      end else din_valid = 1'b0;
      #1;
      if (stall_prev) begin
        n_tests++;
        if (cur_valid !== 1'b1 || cur_rd !== prev_rd || cur_tag !== prev_tag) begin
          n_fail++; $display("FAIL bp_stable[%0d]: got v=%b rd=%h tag=%0d expected 1/%h/%0d",
                             s, cur_valid, cur_rd, cur_tag, prev_rd, prev_tag);
        end
      end
      if (cyc < 5 && sent >= stages_of(s)) begin
        n_tests++;
        if (cur_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_full_ready[%0d]: got %b expected 0 (cycle %0d)", s, cur_ready, cyc);
        end
      end
      if (cur_valid && dout_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra[%0d]: got tag=%0d expected no output", s, cur_tag);
        end else begin
          e = exp_q.pop_front();
          if ({cur_tag, cur_rd[31:0]} !== e || cur_rd[63:32] !== 32'h0) begin
            n_fail++; $display("FAIL bp_order[%0d]: got tag=%0d rd=%h expected %0d/%h",
                               s, cur_tag, cur_rd, e[35:32], e[31:0]);
          end
        end
        got++;
      end
      stall_prev = cur_valid && !dout_ready;
      prev_rd = cur_rd; prev_tag = cur_tag;
      if (din_valid && cur_ready) begin
        exp_q.push_back({sent[3:0], 32'h8000_0000 >> sent});
        sent++;
      end
      cyc++;
    end
    din_valid = 1'b0; dout_ready = 1'b1;
    n_tests++;
    if (got !== 8 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL bp_count[%0d]: got %0d outputs expected 8", s, got);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_tests++;
      if (cur_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_dup[%0d]: got dout_valid=%b expected 0", s, cur_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 0; dout_ready = 1'b0;
    @(negedge clock);
    din_op = OP_SLL; din_w = 1'b0; din_rs1 = 64'h1; din_rs2 = 64'd1; din_tag = 4'd1; din_valid = 1'b1;
    @(negedge clock);
    din_tag = 4'd2;
    @(negedge clock);
    din_valid = 1'b0; reset = 1'b0;
    @(negedge clock);
    n_tests++;
    if (cur_valid !== 1'b0 || cur_rd !== 64'h0 || cur_tag !== 4'h0) begin
      n_fail++; $display("FAIL mid_reset_out: got v=%b rd=%h tag=%0d expected 0/0/0", cur_valid, cur_rd, cur_tag);
    end
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if (cur_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", cur_ready);
    end
    dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_tests++;
      if (cur_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset_stale: got dout_valid=%b tag=%0d expected 0", cur_valid, cur_tag);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    repeat (3) @(negedge clock);
    test_reset();
    test_latency();
    test_op_sweep();
    test_word();
    test_funnel();
    test_back_to_back(0);
    test_back_to_back(2);
    test_back_to_back(1);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
